vedic_mac_sequencer: RTL

//  Sequences a dot-product over an operand-pair stream using a shared combinational

---
 rtl/vedic_mac_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vedic_mac_sequencer.sv
// vedic_mac_sequencer
//   Runs a dot product over a stream of operand pairs. The multiply is done by an
//   external combinational Vedic multiplier: this block routes the accepted pair
//   to it (Mul_A/Mul_B) and takes the product back on Mul_P. Each product is first
//   registered in p_reg and added into the accumulator one cycle later, so the
//   multiplier and the adder never form one combinational path. After Vec_Len
//   pairs the sum is presented on a valid/ready output.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Vec_Len      start a vector of Vec_Len pairs (sampled in IDLE only)
//   In_Valid, In_Ready  operand-pair handshake; In_1/In_2 are the operands
//   Mul_A, Mul_B        to the shared multiplier (zero outside RUN)
//   Mul_P               product from the shared multiplier
//   Out_Valid/Out_Ready result handshake; Result is the sum modulo 2^ACC_W
//   Overflow            sticky carry-out of the accumulator for this vector
//   Busy                high whenever the sequencer is not idle
module vedic_mac_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [LEN_W-1:0]      Vec_Len,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_W-1:0]     In_1,
    input  logic [DATA_W-1:0]     In_2,
    output logic [DATA_W-1:0]     Mul_A,
    output logic [DATA_W-1:0]     Mul_B,
    input  logic [2*DATA_W-1:0]   Mul_P,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [ACC_W-1:0]      Result,
    output logic                  Overflow,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ACC_W-1:0]      acc_reg, acc_next;
    logic                  ovf_reg, ovf_next;
    logic [LEN_W-1:0]      count_reg, count_next;
    logic [2*DATA_W-1:0]   p_reg, p_next;
    logic                  p_vld_reg, p_vld_next;

    logic                  accept;
    logic [ACC_W:0]        p_ext;
    logic [ACC_W:0]        sum;

    // Zero-extend the product by assignment rather than replication so that
    // ACC_W == 2*DATA_W (no padding bits) stays legal.
    always_comb begin
        p_ext                  = '0;
        p_ext[2*DATA_W-1:0]    = p_reg;
    end

    // One extra bit on the adder captures the carry-out for the sticky flag.
    assign sum    = {1'b0, acc_reg} + p_ext;
    assign accept = In_Valid && (state_reg == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            count_reg <= '0;
            p_reg     <= '0;
            p_vld_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            count_reg <= count_next;
            p_reg     <= p_next;
            p_vld_reg <= p_vld_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        count_next = count_reg;
        p_next     = p_reg;
        p_vld_next = p_vld_reg;

        // A pending product is folded in on every cycle it is valid. p_vld is
        // only ever set in RUN, so this covers RUN and the final add in DRAIN.
        if (p_vld_reg) begin
            acc_next = sum[ACC_W-1:0];
            ovf_next = ovf_reg | sum[ACC_W];
        end

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    p_vld_next = 1'b0;
                    if (Vec_Len != '0) begin
                        count_next = Vec_Len;
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    p_next     = Mul_P;
                    p_vld_next = 1'b1;
                    count_next = count_reg - LEN_W'(1);
                    if (count_reg == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end else begin
                    // Bubble: nothing new to add next cycle.
                    p_vld_next = 1'b0;
                end
            end
            DRAIN: begin
                p_vld_next = 1'b0;
                state_next = DONE;
            end
            DONE: begin
                // Start here (including the handoff cycle) is deliberately ignored.
                if (Out_Ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign In_Ready  = (state_reg == RUN);
    assign Mul_A     = (state_reg == RUN) ? In_1 : '0;
    assign Mul_B     = (state_reg == RUN) ? In_2 : '0;
    assign Out_Valid = (state_reg == DONE);
    assign Busy      = (state_reg != IDLE);
    assign Result    = acc_reg;
    assign Overflow  = ovf_reg;

endmodule
